// File: rtl/wash_sequencer_if.sv
// Control and status bundle between the wash program sequencer and the display stage.
// The master drives the button/tick pulses; the slave reports progress.
interface wash_sequencer_if;
    logic        sec_pulse;
    logic        start;
    logic        pause;
    logic [7:0]  mask;
    logic [2:0]  phase;
    logic [7:0]  mask_left;
    logic [7:0]  phase_remain;
    logic [9:0]  remain;
    logic [11:0] remain_bcd;
    logic        running;
    logic        paused;
    logic        done;

    modport master (
        output sec_pulse, start, pause, mask,
        input  phase, mask_left, phase_remain, remain, remain_bcd, running, paused, done
    );

    modport slave (
        input  sec_pulse, start, pause, mask,
        output phase, mask_left, phase_remain, remain, remain_bcd, running, paused, done
    );
endinterface

// File: rtl/wash_sequencer.sv
// Wash program sequencer: walks the enabled phases MSB-first and counts down the
// per-phase and whole-program seconds, with pause/resume and a done pulse.
module wash_sequencer #(
    parameter int T_IN    = 3,
    parameter int T_WASH  = 5,
    parameter int T_OUT   = 2,
    parameter int T_SPIN  = 4,
    parameter int T_RINSE = 4
) (
    input  logic             cp,
    input  logic             rst,
    wash_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t      stateReg, stateNext;
    logic [2:0]  phaseReg, phaseNext;
    logic [7:0]  maskLeftReg, maskLeftNext;
    logic [7:0]  phaseRemainReg, phaseRemainNext;
    logic [9:0]  remainReg, remainNext;
    logic        doneReg, doneNext;

    logic [9:0]  phaseTerm [8];
    logic [9:0]  programTime;
    logic [7:0]  curBit;
    logic [7:0]  maskAfter;

    // Phase k sits on mask bit 7-k: in, wash, out, spin, in, rinse, out, spin.
    function automatic logic [7:0] phaseTime(input logic [2:0] k);
        case (k)
            3'd0, 3'd4: phaseTime = 8'(T_IN);
            3'd1:       phaseTime = 8'(T_WASH);
            3'd2, 3'd6: phaseTime = 8'(T_OUT);
            3'd3, 3'd7: phaseTime = 8'(T_SPIN);
            default:    phaseTime = 8'(T_RINSE);
        endcase
    endfunction

    // Lowest phase index whose bit is set, i.e. the highest set mask bit.
    function automatic logic [2:0] firstPhase(input logic [7:0] m);
        firstPhase = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (m[7 - k]) begin
                firstPhase = 3'(k);
            end
        end
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_term
            assign phaseTerm[gi] = bus.mask[7 - gi] ? {2'b00, phaseTime(3'(gi))} : 10'd0;
        end
    endgenerate

    always_comb begin
        programTime = '0;
        for (int k = 0; k < 8; k++) begin
            programTime = programTime + phaseTerm[k];
        end
    end

    always_ff @(posedge cp) begin
        if (rst) begin
            stateReg       <= IDLE;
            phaseReg       <= '0;
            maskLeftReg    <= '0;
            phaseRemainReg <= '0;
            remainReg      <= '0;
            doneReg        <= 1'b0;
        end else begin
            stateReg       <= stateNext;
            phaseReg       <= phaseNext;
            maskLeftReg    <= maskLeftNext;
            phaseRemainReg <= phaseRemainNext;
            remainReg      <= remainNext;
            doneReg        <= doneNext;
        end
    end

    always_comb begin
        stateNext       = stateReg;
        phaseNext       = phaseReg;
        maskLeftNext    = maskLeftReg;
        phaseRemainNext = phaseRemainReg;
        remainNext      = remainReg;
        doneNext        = 1'b0;
        curBit          = 8'h80 >> phaseReg;
        maskAfter       = maskLeftReg & ~curBit;

        case (stateReg)
            IDLE, DONE: begin
                if (bus.start && (bus.mask != 8'h00)) begin
                    stateNext       = RUN;
                    maskLeftNext    = bus.mask;
                    phaseNext       = firstPhase(bus.mask);
                    phaseRemainNext = phaseTime(firstPhase(bus.mask));
                    remainNext      = programTime;
                end
            end
            RUN: begin
                // A pause pulse swallows a coincident tick.
                if (bus.pause) begin
                    stateNext = PAUSE;
                end else if (bus.sec_pulse) begin
                    remainNext = remainReg - 10'd1;
                    if (phaseRemainReg > 8'd1) begin
                        phaseRemainNext = phaseRemainReg - 8'd1;
                    end else if (maskAfter == 8'h00) begin
                        stateNext       = DONE;
                        doneNext        = 1'b1;
                        maskLeftNext    = '0;
                        phaseRemainNext = '0;
                        remainNext      = '0;
                    end else begin
                        maskLeftNext    = maskAfter;
                        phaseNext       = firstPhase(maskAfter);
                        phaseRemainNext = phaseTime(firstPhase(maskAfter));
                    end
                end
            end
            PAUSE: begin
                if (bus.pause) begin
                    stateNext = RUN;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        bus.phase        = phaseReg;
        bus.mask_left    = maskLeftReg;
        bus.phase_remain = phaseRemainReg;
        bus.remain       = remainReg;
        bus.running      = (stateReg == RUN);
        bus.paused       = (stateReg == PAUSE);
        bus.done         = doneReg;
        bus.remain_bcd   = {4'(remainReg / 10'd100),
                            4'((remainReg / 10'd10) % 10'd10),
                            4'(remainReg % 10'd10)};
    end
endmodule
